// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot-time byte-stream loader that fills instruction memory and holds the cpu in reset
// Optional feature: INSTR_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
module instr_loader #(
    parameter int                 ADDR_W    = 64,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int                 MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR0  = 3'd1;
    localparam logic [2:0] S_HDR1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd7;
    localparam logic [2:0] S_FINAL = S_CHK;
`else
    localparam logic [2:0] S_FINAL = S_DONE;
`endif

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    logic [2:0]  state;
    logic [7:0]  n_lo;
    logic [15:0] words_left;
    logic [1:0]  byte_idx;
    logic [15:0] n_hdr;
    logic        accept;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // Every output is a decode of the registered state, so byte_ready never sees byte_valid.
    always_comb begin
        byte_ready = (state == S_HDR0) || (state == S_HDR1) || (state == S_DATA);
`ifdef INSTR_LOADER_CHECKSUM_EN
        byte_ready = byte_ready || (state == S_CHK);
`endif
        busy = byte_ready || (state == S_WRITE);
    end

    assign mem_we    = (state == S_WRITE);
    assign cpu_reset = (state != S_DONE);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);
    assign accept    = byte_valid && byte_ready;
    assign n_hdr     = {byte_data, n_lo};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            n_lo       <= '0;
            words_left <= '0;
            byte_idx   <= '0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            if (accept && state != S_CHK) begin
                csum <= csum ^ byte_data;
            end
`endif
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_HDR0;
                        mem_addr <= BASE_ADDR;
                        byte_idx <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                S_HDR0: begin
                    if (accept) begin
                        n_lo  <= byte_data;
                        state <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (accept) begin
                        words_left <= n_hdr;
                        if (n_hdr == 16'd0) begin
                            state <= S_FINAL;
                        end else if ({1'b0, n_hdr} > MAX_N) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        mem_wdata[{byte_idx, 3'b000} +: 8] <= byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    mem_addr   <= mem_addr + ADDR_W'(4);
                    words_left <= words_left - 16'd1;
                    state      <= (words_left == 16'd1) ? S_FINAL : S_DATA;
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        state <= (byte_data == csum) ? S_DONE : S_ERR;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        err;

    int vec = 0;
    int miss = 0;
    int acc_cnt = 0;
    int we_bad = 0;
    logic [63:0] wr_a[$];
    logic [31:0] wr_d[$];
    logic [7:0]  prog2[$];
    logic [7:0]  prog1[$];

    instr_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_wdata);
            if (byte_ready) we_bad++;
        end
    end

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive(input logic [7:0] b[$], input bit toggle, input int start_cyc);
        int i = 0;
        int cyc = 0;
        bit ph = 1'b1;
        bit acc;
        while (i < b.size() && cyc < 400) begin
            byte_valid = toggle ? ph : 1'b1;
            byte_data  = b[i];
            start      = (cyc == start_cyc);
            ph         = !ph;
            acc        = byte_valid && byte_ready;
            @(negedge clk);
            if (acc) begin
                i++;
                acc_cnt++;
            end
            cyc++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        vec++;
        if (i != b.size()) begin
            miss++;
            $display("FAIL drive_timeout accepted %0d required %0d", i, b.size());
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        @(negedge clk);
        vec++; if (byte_ready !== 1'b0) begin miss++; $display("FAIL rst_byte_ready got %b exp 0", byte_ready); end
        vec++; if (mem_we !== 1'b0) begin miss++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
        vec++; if (mem_addr !== 64'd0) begin miss++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        vec++; if (mem_wdata !== 32'd0) begin miss++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
        vec++; if (cpu_reset !== 1'b1) begin miss++; $display("FAIL rst_cpu_reset got %b exp 1", cpu_reset); end
        vec++; if ({busy, done, err} !== 3'b000) begin miss++; $display("FAIL rst_flags got %b exp 000", {busy, done, err}); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load;
        acc_cnt = 0; wr_a.delete(); wr_d.delete();
        pulse_start;
        vec++; if ({busy, byte_ready} !== 2'b11) begin miss++; $display("FAIL load_start_latency got %b exp 11", {busy, byte_ready}); end
        drive(prog2, 1'b0, -1);
`ifndef INSTR_LOADER_CHECKSUM_EN
        vec++; if ({mem_we, done, mem_addr} !== {2'b10, 64'd4}) begin miss++; $display("FAIL load_last_write got %b%b/%h exp 10/4", mem_we, done, mem_addr); end
        @(negedge clk);
`endif
        vec++; if ({done, cpu_reset, busy} !== 3'b100) begin miss++; $display("FAIL load_done got %b exp 100", {done, cpu_reset, busy}); end
`ifdef INSTR_LOADER_CHECKSUM_EN
        vec++; if (acc_cnt != 11) begin miss++; $display("FAIL load_accepts got %0d exp 11", acc_cnt); end
`else
        vec++; if (acc_cnt != 10) begin miss++; $display("FAIL load_accepts got %0d exp 10", acc_cnt); end
`endif
        vec++; if (wr_a.size() != 2) begin miss++; $display("FAIL load_nwrites got %0d exp 2", wr_a.size()); end
        else begin
            vec++; if ({wr_a[0], wr_d[0]} !== {64'd0, 32'h00A00513}) begin miss++; $display("FAIL load_w0 got %h:%h exp 0:00a00513", wr_a[0], wr_d[0]); end
            vec++; if ({wr_a[1], wr_d[1]} !== {64'd4, 32'h00100593}) begin miss++; $display("FAIL load_w1 got %h:%h exp 4:00100593", wr_a[1], wr_d[1]); end
        end
    endtask

    task automatic test_toggle;
        wr_a.delete(); wr_d.delete(); we_bad = 0;
        pulse_start;
        vec++; if ({mem_addr, done, cpu_reset} !== {64'd0, 2'b01}) begin miss++; $display("FAIL tog_restart got %h/%b%b exp 0/01", mem_addr, done, cpu_reset); end
        drive(prog2, 1'b1, -1);
        repeat (2) @(negedge clk);
        vec++; if (done !== 1'b1) begin miss++; $display("FAIL tog_done got %b exp 1", done); end
        vec++; if (we_bad != 0) begin miss++; $display("FAIL tog_we_while_ready got %0d exp 0", we_bad); end
        vec++; if (wr_a.size() != 2) begin miss++; $display("FAIL tog_nwrites got %0d exp 2", wr_a.size()); end
        else begin
            vec++; if ({wr_a[0], wr_d[0], wr_a[1], wr_d[1]} !== {64'd0, 32'h00A00513, 64'd4, 32'h00100593}) begin
                miss++; $display("FAIL tog_writes got %h:%h %h:%h", wr_a[0], wr_d[0], wr_a[1], wr_d[1]);
            end
        end
    endtask

    task automatic test_start_ignored;
        wr_a.delete(); wr_d.delete();
        pulse_start;
        drive(prog2, 1'b0, 5);
        repeat (2) @(negedge clk);
        vec++; if ({done, cpu_reset} !== 2'b10) begin miss++; $display("FAIL ign_done got %b exp 10", {done, cpu_reset}); end
        vec++; if (wr_a.size() != 2) begin miss++; $display("FAIL ign_nwrites got %0d exp 2", wr_a.size()); end
        else begin
            vec++; if ({wr_a[1], wr_d[1]} !== {64'd4, 32'h00100593}) begin miss++; $display("FAIL ign_w1 got %h:%h exp 4:00100593", wr_a[1], wr_d[1]); end
        end
    endtask

    task automatic test_max_err;
        logic [7:0] hdr[$];
        hdr = '{8'h01, 8'h01};
        wr_a.delete(); wr_d.delete();
        pulse_start;
        drive(hdr, 1'b0, -1);
        vec++; if ({err, cpu_reset, done, busy} !== 4'b1100) begin miss++; $display("FAIL max_err got %b exp 1100", {err, cpu_reset, done, busy}); end
        @(negedge clk);
        vec++; if (wr_a.size() != 0) begin miss++; $display("FAIL max_nwrites got %0d exp 0", wr_a.size()); end
        pulse_start;
        vec++; if ({err, busy, byte_ready} !== 3'b011) begin miss++; $display("FAIL max_restart got %b exp 011", {err, busy, byte_ready}); end
    endtask

    task automatic test_mid_reset;
        logic [7:0] part[$];
        part = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wr_a.delete(); wr_d.delete();
        pulse_start;
        drive(part, 1'b0, -1);
        reset = 1'b0;
        #1;
        vec++; if ({byte_ready, mem_we, cpu_reset, busy, done, err} !== 6'b001000) begin
            miss++; $display("FAIL mid_rst_flags got %b exp 001000", {byte_ready, mem_we, cpu_reset, busy, done, err});
        end
        vec++; if ({mem_addr, mem_wdata} !== 96'd0) begin miss++; $display("FAIL mid_rst_data got %h/%h exp 0/0", mem_addr, mem_wdata); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vec++; if (wr_a.size() != 2) begin miss++; $display("FAIL mid_nwrites got %0d exp 2", wr_a.size()); end
        else begin
            vec++; if ({wr_a[0], wr_d[0], wr_a[1], wr_d[1]} !== {64'd0, 32'h44332211, 64'd4, 32'h88776655}) begin
                miss++; $display("FAIL mid_kept got %h:%h %h:%h", wr_a[0], wr_d[0], wr_a[1], wr_d[1]);
            end
        end
        pulse_start;
        drive(prog1, 1'b0, -1);
        repeat (2) @(negedge clk);
        vec++; if (done !== 1'b1) begin miss++; $display("FAIL mid_reload_done got %b exp 1", done); end
        vec++; if (wr_a.size() != 3) begin miss++; $display("FAIL mid_reload_nwrites got %0d exp 3", wr_a.size()); end
        else begin
            vec++; if ({wr_a[2], wr_d[2]} !== {64'd0, 32'h00000013}) begin miss++; $display("FAIL mid_reload got %h:%h exp 0:00000013", wr_a[2], wr_d[2]); end
        end
    endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        logic [7:0] bad[$];
        bad = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        pulse_start;
        drive(prog1, 1'b0, -1);
        vec++; if ({done, err, cpu_reset} !== 3'b100) begin miss++; $display("FAIL chk_good got %b exp 100", {done, err, cpu_reset}); end
        pulse_start;
        drive(bad, 1'b0, -1);
        vec++; if ({done, err, cpu_reset} !== 3'b011) begin miss++; $display("FAIL chk_bad got %b exp 011", {done, err, cpu_reset}); end
    endtask
`endif

    initial begin
        prog2 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        prog1 = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
`ifdef INSTR_LOADER_CHECKSUM_EN
        prog2.push_back(8'h32);
        prog1.push_back(8'h12);
`endif
        test_reset;
        test_load;
        test_toggle;
        test_start_ignored;
        test_max_err;
        test_mid_reset;
`ifdef INSTR_LOADER_CHECKSUM_EN
        test_checksum;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
